// File: rtl/dct_coef_sequencer_if.sv
// dct_coef_sequencer_if: start/status, pixel fetch, cosine LUT selector and
// coefficient output bundle for the 8x8 DCT coefficient sequencer.
// master = sequencer side, slave = surrounding buffers / LUT / consumer.
interface dct_coef_sequencer_if #(
   parameter int COEF_W = 16
);
   logic                start;
   logic                busy;
   logic                done;
   logic                pix_rd;
   logic [5:0]          pix_addr;
   logic [7:0]          pix_data;
   logic [2:0]          k1;
   logic [2:0]          k2;
   logic [2:0]          n1;
   logic [2:0]          n2;
   logic signed [31:0]  cos_term;
   logic                coef_valid;
   logic                coef_ready;
   logic [5:0]          coef_addr;
   logic [COEF_W-1:0]   coef_data;

   modport master (
      input  start, pix_data, cos_term, coef_ready,
      output busy, done, pix_rd, pix_addr, k1, k2, n1, n2,
             coef_valid, coef_addr, coef_data
   );

   modport slave (
      output start, pix_data, cos_term, coef_ready,
      input  busy, done, pix_rd, pix_addr, k1, k2, n1, n2,
             coef_valid, coef_addr, coef_data
   );
endinterface

// File: rtl/dct_coef_sequencer.sv
// dct_coef_sequencer: walks all 64 (n1,n2) points for each of the 64 (k1,k2)
// coefficients of an 8x8 block, multiply-accumulates pixel * cosine and
// emits the rounded, scaled coefficient on a valid/ready port.
// Build option: DCT_LEVEL_SHIFT_EN - subtract 128 from each pixel before the
// MAC (signed -128..127); otherwise pixels are zero-extended (0..255).
module dct_coef_sequencer #(
   parameter int FRAC_BITS = 8,
   parameter int COEF_W    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   dct_coef_sequencer_if.master  bus
);
   typedef enum logic [2:0] {IDLE, RUN, DRAIN, WRITE, DONE} state_t;

   localparam logic signed [31:0] RND = 32'sd1 <<< (FRAC_BITS - 1);

   state_t             state;
   logic [5:0]         kidx;     // {k1,k2}
   logic [5:0]         nidx;     // {n1,n2}
   logic               mac_vld;  // pixel for last cycle's read is on pix_data now
   logic signed [31:0] cos_q;
   logic signed [31:0] acc;
   logic signed [8:0]  pix_term;
   logic signed [31:0] prod;
   logic signed [31:0] acc_sum;

`ifdef DCT_LEVEL_SHIFT_EN
   assign pix_term = $signed({1'b0, bus.pix_data}) - 9'sd128;
`else
   assign pix_term = $signed({1'b0, bus.pix_data});
`endif

   // cos_q was captured alongside the pixel read, so both line up in the MAC cycle
   assign prod    = 32'(pix_term) * cos_q;
   assign acc_sum = mac_vld ? acc + prod : acc;

   // selectors and addresses come straight from the counters; kidx only moves
   // on a handshake so coef_addr stays stable through backpressure
   assign bus.k1        = kidx[5:3];
   assign bus.k2        = kidx[2:0];
   assign bus.n1        = nidx[5:3];
   assign bus.n2        = nidx[2:0];
   assign bus.pix_addr  = nidx;
   assign bus.coef_addr = kidx;

   // sequencer FSM with registered outputs and the MAC accumulator
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         kidx           <= '0;
         nidx           <= '0;
         mac_vld        <= 1'b0;
         cos_q          <= '0;
         acc            <= '0;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
         bus.pix_rd     <= 1'b0;
         bus.coef_valid <= 1'b0;
         bus.coef_data  <= '0;
      end else begin
         mac_vld  <= (state == RUN);
         acc      <= acc_sum;
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  kidx       <= '0;
                  nidx       <= '0;
                  acc        <= '0;
                  bus.busy   <= 1'b1;
                  bus.pix_rd <= 1'b1;
                  state      <= RUN;
               end
            end
            RUN: begin
               cos_q <= bus.cos_term;
               nidx  <= nidx + 6'd1;
               if (nidx == 6'd63) begin
                  bus.pix_rd <= 1'b0;
                  state      <= DRAIN;
               end
            end
            DRAIN: begin
               // last MAC lands this cycle; round from the final sum directly
               bus.coef_valid <= 1'b1;
               bus.coef_data  <= COEF_W'((acc_sum + RND) >>> FRAC_BITS);
               state          <= WRITE;
            end
            WRITE: begin
               if (bus.coef_ready) begin
                  bus.coef_valid <= 1'b0;
                  acc            <= '0;
                  nidx           <= '0;
                  kidx           <= kidx + 6'd1;
                  if (kidx == 6'd63) begin
                     bus.done <= 1'b1;
                     state    <= DONE;
                  end else begin
                     bus.pix_rd <= 1'b1;
                     state      <= RUN;
                  end
               end
            end
            DONE: begin
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dct_coef_sequencer.sv
// tb_dct_coef_sequencer: directed checks of reset, block sequencing, address
// order, backpressure, rounding/sign and start filtering.
`timescale 1ns/1ps
module tb_dct_coef_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dct_coef_sequencer_if #(.COEF_W(16)) bus();

   dct_coef_sequencer #(.FRAC_BITS(8), .COEF_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

`ifdef DCT_LEVEL_SHIFT_EN
   localparam logic [15:0] EXP_FLAT = 16'h0000;  // 128-128 = 0 everywhere
   localparam logic [15:0] EXP_SIGN = 16'h0000;  // (-127+128)>>>8 = 0
`else
   localparam logic [15:0] EXP_FLAT = 16'd1024;  // 64*128*32 = 262144, /256
   localparam logic [15:0] EXP_SIGN = 16'hFFFF;  // (-255+128)>>>8 = -1
`endif

   int   n_cmp = 0;
   int   n_bad = 0;
   logic lut_mode = 1'b0;
   logic [7:0] pix_mem [64];

   // cosine LUT stand-in: flat 32, or -1 only at (n1,n2)=(0,0)
   assign bus.cos_term = !lut_mode ? 32'sd32 :
                         ((bus.n1 == 3'd0 && bus.n2 == 3'd0) ? -32'sd1 : 32'sd0);

   // pixel buffer stand-in: data one cycle after the read strobe
   always @(posedge clk or posedge rst) begin
      if (rst) bus.pix_data <= 8'd0;
      else if (bus.pix_rd) bus.pix_data <= pix_mem[bus.pix_addr];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   int r_span, r_ncoef, r_addr_err, r_data_err, r_pix_err, r_npix, r_stab_err, r_stalls;

   task automatic run_block(input int stall_coef, input int stall_len, input int poke_cyc,
                            input logic [15:0] exp_data);
      int first_rd;
      logic held;
      logic [5:0] h_addr;
      logic [15:0] h_data;
      r_span = -1; r_ncoef = 0; r_addr_err = 0; r_data_err = 0;
      r_pix_err = 0; r_npix = 0; r_stab_err = 0; r_stalls = 0;
      first_rd = -1; held = 1'b0; h_addr = '0; h_data = '0;
      bus.coef_ready = 1'b1;
      @(negedge clk); bus.start = 1'b1;
      @(negedge clk);
      for (int cyc = 0; cyc < 6000; cyc++) begin
         bus.start = (cyc == poke_cyc);
         if (bus.pix_rd && first_rd < 0) first_rd = cyc;
         if (bus.pix_rd && r_ncoef == 0) begin
            if (bus.pix_addr != r_npix[5:0]) r_pix_err++;
            r_npix++;
         end
         if (bus.done) begin
            r_span = cyc - first_rd;
            break;
         end
         if (bus.coef_valid) begin
            if (held) begin
               if (bus.coef_addr != h_addr || bus.coef_data != h_data) r_stab_err++;
            end else begin
               h_addr = bus.coef_addr; h_data = bus.coef_data; held = 1'b1;
            end
            if (int'(bus.coef_addr) == stall_coef && r_stalls < stall_len) begin
               bus.coef_ready = 1'b0;
               r_stalls++;
            end else begin
               bus.coef_ready = 1'b1;
               if (int'(bus.coef_addr) != r_ncoef) r_addr_err++;
               if (bus.coef_data != exp_data) r_data_err++;
               r_ncoef++;
               held = 1'b0;
            end
         end else begin
            bus.coef_ready = 1'b1;
         end
         @(negedge clk);
      end
      bus.start = 1'b0;
      bus.coef_ready = 1'b1;
   endtask

   initial begin
      logic any;
      bus.start = 1'b0;
      bus.coef_ready = 1'b1;
      for (int i = 0; i < 64; i++) pix_mem[i] = 8'd128;

      // reset values while rst is held
      repeat (3) @(negedge clk);
      chk("rst_busy",       32'(bus.busy),       32'd0);
      chk("rst_done",       32'(bus.done),       32'd0);
      chk("rst_pix_rd",     32'(bus.pix_rd),     32'd0);
      chk("rst_coef_valid", 32'(bus.coef_valid), 32'd0);
      chk("rst_pix_addr",   32'(bus.pix_addr),   32'd0);
      chk("rst_coef_addr",  32'(bus.coef_addr),  32'd0);
      chk("rst_coef_data",  32'(bus.coef_data),  32'd0);
      chk("rst_sel",        32'({bus.k1, bus.k2, bus.n1, bus.n2}), 32'd0);

      // idle for 100 cycles: nothing moves
      rst = 1'b0;
      any = 1'b0;
      repeat (100) begin
         @(negedge clk);
         any |= bus.busy | bus.done | bus.pix_rd | bus.coef_valid | (|bus.pix_addr) |
                (|bus.coef_addr) | (|bus.coef_data) | (|{bus.k1, bus.k2, bus.n1, bus.n2});
      end
      chk("idle_quiet", 32'(any), 32'd0);

      // reset pulse at RUN cycle 30
      bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      repeat (30) @(negedge clk);
      chk("midrst_in_run", 32'(bus.pix_rd), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_busy",   32'(bus.busy),   32'd0);
      chk("midrst_pix_rd", 32'(bus.pix_rd), 32'd0);
      @(negedge clk); rst = 1'b0;
      any = 1'b0;
      repeat (100) begin
         @(negedge clk);
         any |= bus.coef_valid | bus.busy | bus.done;
      end
      chk("midrst_no_coef", 32'(any), 32'd0);

      // flat block, start poked mid-block
      run_block(64, 0, 500, EXP_FLAT);
      chk("flat_ncoef",    32'(r_ncoef),    32'd64);
      chk("flat_addr_err", 32'(r_addr_err), 32'd0);
      chk("flat_data_err", 32'(r_data_err), 32'd0);
      chk("flat_npix",     32'(r_npix),     32'd64);
      chk("flat_pix_err",  32'(r_pix_err),  32'd0);
      chk("flat_span",     32'(r_span),     32'd4224);

      // start on the done cycle is ignored
      bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      chk("donestart_busy",   32'(bus.busy),   32'd0);
      chk("donestart_pix_rd", 32'(bus.pix_rd), 32'd0);
      @(negedge clk);
      chk("donestart_idle",   32'(bus.pix_rd | bus.busy), 32'd0);

      // backpressure on coefficient 3
      run_block(3, 5, -1, EXP_FLAT);
      chk("bp_stalls",   32'(r_stalls),   32'd5);
      chk("bp_stable",   32'(r_stab_err), 32'd0);
      chk("bp_ncoef",    32'(r_ncoef),    32'd64);
      chk("bp_addr_err", 32'(r_addr_err), 32'd0);
      chk("bp_data_err", 32'(r_data_err), 32'd0);
      chk("bp_span",     32'(r_span),     32'd4229);

      // sign and rounding
      lut_mode = 1'b1;
      for (int i = 0; i < 64; i++) pix_mem[i] = 8'd0;
      pix_mem[0] = 8'd255;
      run_block(64, 0, -1, EXP_SIGN);
      chk("sign_ncoef",    32'(r_ncoef),    32'd64);
      chk("sign_data_err", 32'(r_data_err), 32'd0);
      chk("sign_addr_err", 32'(r_addr_err), 32'd0);
      chk("sign_span",     32'(r_span),     32'd4224);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
